// File: rtl/math_result_tx.sv
// Starts a doMath run, waits for its complete edge with a watchdog, then
// sends X/Y as an 8-byte 8N1 UART frame: SYNC, X[31:0], Y[15:0], XOR checksum.
module math_result_tx #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        arm,
  output logic        startSequence,
  input  logic        complete,
  input  logic [31:0] X,
  input  logic [15:0] Y,
  output logic        tx,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam int BCW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, SEND} state_t;

  state_t        state_q, state_d;
  logic          complete_q;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   to_cnt_q, to_cnt_d;
  logic [63:0]   frame_q, frame_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic       cmp_edge;
  logic       bit_end, byte_end, frame_end, to_expire;
  logic [7:0] chk_byte;
  logic [7:0] cur_byte;
  logic [2:0] data_sel;

  assign cmp_edge  = complete & ~complete_q;
  assign bit_end   = (bit_cnt_q == BCW'(CLKS_PER_BIT - 1));
  assign byte_end  = bit_end && (bit_idx_q == 4'd9);
  assign frame_end = byte_end && (byte_idx_q == 3'd7);
  assign to_expire = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign chk_byte  = X[31:24] ^ X[23:16] ^ X[15:8] ^ X[7:0] ^ Y[15:8] ^ Y[7:0];
  assign cur_byte  = frame_q[63:56];
  assign data_sel  = 3'(bit_idx_q - 4'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (arm) state_d = PULSE;
      PULSE: state_d = WAIT;
      // A complete edge on the expiry cycle still counts as a result.
      WAIT: begin
        if (cmp_edge)       state_d = SEND;
        else if (to_expire) state_d = IDLE;
      end
      SEND:  if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    startSequence = (state_q == PULSE);
    busy          = (state_q != IDLE);
    overrun       = overrun_q;
    timeout       = timeout_q;
    tx            = 1'b1;
    if (state_q == SEND) begin
      if (bit_idx_q == 4'd0)      tx = 1'b0;
      else if (bit_idx_q <= 4'd8) tx = cur_byte[data_sel];
    end
  end

  always_comb begin
    bit_cnt_d  = '0;
    bit_idx_d  = '0;
    byte_idx_d = '0;
    to_cnt_d   = '0;
    frame_d    = frame_q;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;

    if (state_q == IDLE && arm) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (cmp_edge && state_q != WAIT) overrun_d = 1'b1;

    if (state_q == WAIT) begin
      to_cnt_d = to_cnt_q + 32'd1;
      if (cmp_edge) frame_d = {SYNC_BYTE, X, Y, chk_byte};
      else if (to_expire) timeout_d = 1'b1;
    end

    // Bits are sent from the top byte of the frame register, shifting a byte at a time.
    if (state_q == SEND) begin
      bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      if (bit_end) bit_idx_d = (bit_idx_q == 4'd9) ? 4'd0 : bit_idx_q + 4'd1;
      if (byte_end) begin
        byte_idx_d = byte_idx_q + 3'd1;
        frame_d    = {frame_q[55:0], 8'h00};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      complete_q <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      to_cnt_q   <= '0;
      frame_q    <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      complete_q <= complete;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      to_cnt_q   <= to_cnt_d;
      frame_q    <= frame_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_math_result_tx.sv
// Bench for math_result_tx: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model of the expected line.
module tb_math_result_tx;
  localparam int CPB   = 4;
  localparam int TO    = 100;
  localparam int FRAME = 80 * CPB;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        arm = 1'b0;
  logic        complete = 1'b0;
  logic [31:0] X = '0;
  logic [15:0] Y = '0;
  logic        startSequence, tx, busy, overrun, timeout;

  int checks = 0;
  int failures = 0;

  math_result_tx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .arm(arm), .startSequence(startSequence),
    .complete(complete), .X(X), .Y(Y), .tx(tx), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [31:0] x, input logic [15:0] y);
    logic [7:0] c;
    c = x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0];
    return {8'hA5, x, y, c};
  endfunction

  // Reference model: the line is a queue of expected per-cycle tx values.
  localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_SEND = 3;
  int   m_mode = M_IDLE;
  int   m_wcnt = 0;
  bit   m_cprev = 1'b0;
  bit   m_ovr = 1'b0;
  bit   m_to = 1'b0;
  bit   m_txq[$];

  task automatic load_frame(input logic [63:0] f);
    logic [7:0] b;
    bit v;
    m_txq.delete();
    for (int k = 0; k < 8; k++) begin
      b = f[63 - 8*k -: 8];
      for (int j = 0; j < 10; j++) begin
        v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
        for (int c = 0; c < CPB; c++) m_txq.push_back(v);
      end
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    bit cedge;
    if (!RST) begin
      m_mode = M_IDLE; m_wcnt = 0; m_cprev = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
      m_txq.delete();
    end else begin
      cedge = complete && !m_cprev;
      m_cprev = complete;
      case (m_mode)
        M_IDLE: begin
          if (arm) begin m_ovr = 1'b0; m_to = 1'b0; m_mode = M_PULSE; end
          if (cedge) m_ovr = 1'b1;
        end
        M_PULSE: begin
          if (cedge) m_ovr = 1'b1;
          m_mode = M_WAIT; m_wcnt = 0;
        end
        M_WAIT: begin
          if (cedge) begin load_frame(frame_of(X, Y)); m_mode = M_SEND; end
          else if (m_wcnt == TO - 1) begin m_to = 1'b1; m_mode = M_IDLE; end
          else m_wcnt++;
        end
        default: begin
          if (cedge) m_ovr = 1'b1;
          void'(m_txq.pop_front());
          if (m_txq.size() == 0) m_mode = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    chk("tx", tx, (m_mode == M_SEND) ? m_txq[0] : 1'b1);
    chk("busy", busy, m_mode != M_IDLE);
    chk("startSequence", startSequence, m_mode == M_PULSE);
    chk("overrun", overrun, m_ovr);
    chk("timeout", timeout, m_to);
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  logic smp[FRAME];

  task automatic decode(input logic [63:0] f, input string tag);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) b[j] = smp[k*10*CPB + (j+1)*CPB + CPB/2];
      chk({tag, "_byte"}, b, f[63 - 8*k -: 8]);
      chk({tag, "_framing"}, {smp[k*10*CPB + CPB/2], smp[k*10*CPB + 9*CPB + CPB/2]}, 2'b01);
    end
  endtask

  task automatic run_frame(input logic [31:0] x, input logic [15:0] y,
                           input bit stab, input bit ovr_inj);
    complete = 1'b0; arm = 1'b1;
    tick;
    @(negedge CLK);
    chk("busy_on_accept", busy, 1);
    chk("overrun_cleared_on_arm", overrun, 0);
    arm = 1'b0;
    tick; tick; tick;
    X = x; Y = y; complete = 1'b1;
    @(negedge CLK);
    chk("tx_idle_before_edge", tx, 1);
    @(posedge CLK);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      smp[i] = tx;
      if (i == 0) chk("tx_falls_after_edge", tx, 0);
      if (i == FRAME - 1) chk("busy_last_stop_cycle", busy, 1);
      if (stab && i == 5) begin X = 32'hFFFF_FFFF; Y = 16'h0000; end
      if (ovr_inj && i == 10) complete = 1'b0;
      if (ovr_inj && i == 20) complete = 1'b1;
    end
    @(negedge CLK);
    chk("busy_falls_after_frame", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pcnt;
    logic [31:0] rx;
    logic [15:0] ry;

    // Reset held with arm and complete active.
    arm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      complete = ~complete;
    end
    @(negedge CLK);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    arm = 1'b0; complete = 1'b0;
    tick;
    RST = 1'b1;
    tick; tick;

    // Start pulse with arm held for 10 cycles, then timeout expiry.
    arm = 1'b1;
    pcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      @(negedge CLK);
      if (i == 0) begin
        chk("busy_after_arm", busy, 1);
        chk("start_one_cycle_after_arm", startSequence, 1);
      end
      if (i == 1) chk("start_drops", startSequence, 0);
      if (startSequence) pcnt++;
    end
    chk("start_pulse_count", pcnt, 1);
    arm = 1'b0;
    for (int i = 10; i <= 100; i++) tick;
    @(negedge CLK);
    chk("busy_before_expiry", busy, 1);
    chk("timeout_before_expiry", timeout, 0);
    tick;
    @(negedge CLK);
    chk("timeout_at_expiry", timeout, 1);
    chk("busy_at_expiry", busy, 0);
    chk("tx_after_timeout", tx, 1);

    // Complete edge on the expiry cycle wins.
    arm = 1'b1; tick;
    arm = 1'b0; tick;
    for (int i = 0; i < 99; i++) tick;
    complete = 1'b1;
    tick;
    @(negedge CLK);
    chk("edge_wins_timeout", timeout, 0);
    chk("edge_wins_busy", busy, 1);
    chk("edge_wins_tx", tx, 0);
    for (int i = 0; i < FRAME + 4; i++) tick;
    complete = 1'b0;
    tick;

    // Known frame, with X/Y disturbed mid-frame.
    run_frame(32'h0001E8F4, 16'h0163, 1'b1, 1'b0);
    decode(64'hA5_0001E8F4_0163_7F, "known_frame");

    // Edge while idle, then an edge during SEND.
    complete = 1'b0; tick;
    complete = 1'b1; tick;
    @(negedge CLK);
    chk("overrun_idle_edge", overrun, 1);
    rx = $urandom; ry = 16'($urandom);
    run_frame(rx, ry, 1'b0, 1'b1);
    decode(frame_of(rx, ry), "overrun_frame");
    chk("overrun_during_send", overrun, 1);

    // Reset in the start bit of the second byte.
    complete = 1'b0; arm = 1'b1; tick;
    arm = 1'b0; tick; tick;
    X = $urandom; Y = 16'($urandom); complete = 1'b1;
    @(posedge CLK);
    for (int i = 0; i <= 10*CPB + 1; i++) @(negedge CLK);
    chk("tx_start_bit_before_reset", tx, 0);
    #1 RST = 1'b0;
    #1;
    chk("tx_async_reset", tx, 1);
    chk("busy_async_reset", busy, 0);
    tick; tick;
    complete = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 50; i++) tick;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      tick;
      arm = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) complete = ~complete;
      X = $urandom;
      Y = 16'($urandom);
    end
    arm = 1'b0; complete = 1'b0;
    for (int i = 0; i < FRAME + 20; i++) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/math_result_tx.md
Name: math_result_tx

Overview:
- Initiator and reader on the far side of the doMath measurement interface.
- On request, pulses startSequence to doMath and waits for the rising edge of complete.
- Latches X (32 b) and Y (16 b) on that edge, then serializes them as a framed 8N1 UART packet for host readout.
- Watchdogs a missing complete and flags results that arrive when not expected.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (115200 baud at 100 MHz); must be at least 2.
- TIMEOUT_CYCLES, 1000000, maximum number of WAIT cycles before the run is abandoned.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-low reset.
- arm  in  1  request one measurement run; sampled each cycle.
- startSequence  out  1  one-cycle start pulse to doMath.
- complete  in  1  doMath done level; only its rising edge is used.
- X  in  32  doMath result X.
- Y  in  16  doMath result Y.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high from arm acceptance until the end of the frame or a timeout.
- overrun  out  1  sticky; a complete edge arrived outside WAIT.
- timeout  out  1  sticky; TIMEOUT_CYCLES elapsed with no complete edge.

Behaviour:
- Reset (RST=0, takes effect immediately):
  - tx=1; startSequence, busy, overrun and timeout all 0.
  - Latches, counters and the complete edge register all cleared.
  - State = IDLE.
- States: IDLE, PULSE, WAIT, SEND.
- Rising edge of complete = complete && !complete_q, where complete_q is complete registered every cycle.
- IDLE:
  - If arm=1 at a posedge, next state is PULSE.
  - overrun and timeout clear at that edge.
  - busy rises at that edge.
- PULSE:
  - startSequence=1 for exactly this one cycle.
  - Always moves to WAIT next.
- WAIT:
  - Timeout counter starts at 0 on the first WAIT cycle and increments every WAIT cycle.
  - On a complete edge: latch X and Y, form the frame, move to SEND.
  - If the counter reaches TIMEOUT_CYCLES-1 with no edge: timeout=1, busy=0, back to IDLE, tx never toggles.
  - If a complete edge and the timeout expiry fall on the same cycle, the edge wins and no timeout is flagged.
- Frame contents, 8 bytes in this order:
  - SYNC_BYTE
  - X[31:24], X[23:16], X[15:8], X[7:0]
  - Y[15:8], Y[7:0]
  - CHK = XOR of the six data bytes (SYNC_BYTE excluded)
- Byte format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes.
- SEND timing:
  - The first start bit drives tx low on the cycle after the complete edge is detected.
  - Frame length is 80*CLKS_PER_BIT cycles.
  - After the last stop-bit cycle: busy=0 and state=IDLE.
  - An arm in that first IDLE cycle is accepted.
- Data stability: X and Y are read only at the latch edge. Later changes on X or Y never alter a frame in flight.
- arm while busy=1 is ignored; it is neither queued nor counted.
- overrun:
  - A complete edge seen in IDLE, PULSE or SEND sets overrun=1.
  - That data is discarded and tx is unaffected.
  - overrun clears only on the next accepted arm or on reset.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is abandoned. No partial byte resumes after release.
- Internal widths:
  - Bit-time counter: ceil(log2(CLKS_PER_BIT)) bits.
  - Timeout counter: 32 bits.
  - Counters never wrap silently; each reloads to 0 on state entry.

Test Plan:
- Reset: hold RST=0 with arm=1 and complete toggling → tx=1, startSequence=0, busy=0, overrun=0, timeout=0 throughout. Assert RST=0 mid-byte → tx=1 within the same timestep.
- Start pulse: RST released, arm=1 for 1 cycle → busy=1 from the next edge; startSequence=1 for exactly one cycle, one cycle after arm; no second pulse while arm is held high for 10 cycles.
- Normal frame (CLKS_PER_BIT=4): complete rises with X=32'h0001E8F4, Y=16'h0163.
  - Expected bytes: A5 00 01 E8 F4 01 63 7F, each 8N1, 40 cycles per byte.
  - tx falls 1 cycle after the edge; busy falls after 320 cycles.
- Data stability: during the same frame, set X=32'hFFFFFFFF and Y=16'h0000 after 5 cycles → decoded bytes are unchanged: A5 00 01 E8 F4 01 63 7F.
- Overrun: complete edge while IDLE, then another during SEND → overrun=1, tx unchanged, frame unchanged; next arm → overrun=0.
- Timeout (TIMEOUT_CYCLES=100): arm, no complete → timeout=1 and busy=0 exactly 100 cycles after the first WAIT cycle; tx stays 1. A repeat run with the complete edge on the expiry cycle → frame sent, timeout=0.
